// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational 32-bit ALU: a DEPTH-entry request FIFO plus a registered result slot.
// Optional ALU_ISSUE_FLAGS_EN adds registered out_zero/out_neg result flags.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [3:0]       in_inst,
    input  logic             in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_inst,
    output logic             alu_sel,
    input  logic [31:0]      alu_z,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic             out_zero,
    output logic             out_neg,
`endif
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       inst;
        logic             sel;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q;
    logic [31:0]     out_z_q;
    logic [TAG_W-1:0] out_tag_q;
    logic            not_empty;
    logic            push;
    logic            pop;

    assign not_empty = (count_q != '0);
    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count_q != FULL);
    assign push      = in_valid & in_ready;
    assign pop       = not_empty & (~out_valid_q | out_ready);
    assign head      = mem_q[rptr_q];

    assign alu_a    = not_empty ? head.a    : '0;
    assign alu_b    = not_empty ? head.b    : '0;
    assign alu_inst = not_empty ? head.inst : '0;
    assign alu_sel  = not_empty ? head.sel  : 1'b0;

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; stale contents are never visible because alu_* are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= '{a: in_a, b: in_b, inst: in_inst, sel: in_sel, tag: in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (pop) begin
                out_valid_q <= 1'b1;
                out_z_q     <= alu_z;
                out_tag_q   <= head.tag;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic out_zero_q;
    logic out_neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
        end else if (pop) begin
            out_zero_q <= (alu_z == 32'd0);
            out_neg_q  <= alu_z[31];
        end
    end

    assign out_zero = out_zero_q;
    assign out_neg  = out_neg_q;
`endif

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_tag   = out_tag_q;

endmodule
